// File: rtl/fifo_sync_ext_if.sv
// Handshake and status bundle for fifo_sync_ext.
// The FIFO takes the slave modport; its user takes the master modport.
interface fifo_sync_ext_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 4
);
   logic                  flush;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  wr_en;
   logic                  full;
   logic                  almost_full;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  empty;
   logic                  almost_empty;
   logic [ADDR_WIDTH:0]   af_thresh;
   logic [ADDR_WIDTH:0]   ae_thresh;
   logic [ADDR_WIDTH:0]   count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output flush, wr_data, wr_en, rd_en,
      output af_thresh, ae_thresh,
      input  full, almost_full, rd_data, rd_valid,
      input  empty, almost_empty, count,
      input  overflow, underflow
   );

   modport slave (
      input  flush, wr_data, wr_en, rd_en,
      input  af_thresh, ae_thresh,
      output full, almost_full, rd_data, rd_valid,
      output empty, almost_empty, count,
      output overflow, underflow
   );
endinterface

// File: rtl/fifo_sync_ext.sv
// Single-clock FIFO with standard or first-word-fall-through read,
// fill count, programmable thresholds, sticky error flags and flush.
module fifo_sync_ext #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 4,
   parameter int FWFT       = 0
) (
   input  logic           clk,
   input  logic           rst_n,
   fifo_sync_ext_if.slave f
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int PW    = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] ONE   = PW'(1);
   localparam logic [PW-1:0] FULLC = PW'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         wr_ptr, rd_ptr, cnt;
   logic [PW-1:0]         rd_ptr_nxt, cnt_nxt;
   logic [DATA_WIDTH-1:0] rd_q, rd_src;
   logic                  vld_q, vld_nxt, rd_load;
   logic                  ovf_q, udf_q;
   logic                  full, empty;
   logic                  wr_acc, rd_acc;

   assign full  = (cnt == FULLC);
   assign empty = (cnt == '0);

   always_comb begin
      wr_acc     = f.wr_en && !full && !f.flush;
      rd_acc     = f.rd_en && !empty && !f.flush;
      cnt_nxt    = cnt;
      rd_ptr_nxt = rd_ptr;
      vld_nxt    = 1'b0;
      rd_load    = 1'b0;
      rd_src     = mem[rd_ptr[ADDR_WIDTH-1:0]];
      if (wr_acc && !rd_acc) cnt_nxt = cnt + ONE;
      if (rd_acc && !wr_acc) cnt_nxt = cnt - ONE;
      if (rd_acc) rd_ptr_nxt = rd_ptr + ONE;
      if (FWFT != 0) begin
         // output register always tracks the next head; bypass when
         // the head is the word being written on this same edge
         vld_nxt = (cnt_nxt != '0);
         rd_load = vld_nxt;
         if (wr_acc && rd_ptr_nxt == wr_ptr)
            rd_src = f.wr_data;
         else
            rd_src = mem[rd_ptr_nxt[ADDR_WIDTH-1:0]];
      end else begin
         vld_nxt = rd_acc;
         rd_load = rd_acc;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr[ADDR_WIDTH-1:0]] <= f.wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         rd_q   <= '0;
         vld_q  <= 1'b0;
         ovf_q  <= 1'b0;
         udf_q  <= 1'b0;
      end else if (f.flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         vld_q  <= 1'b0;
         ovf_q  <= 1'b0;
         udf_q  <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + ONE;
         rd_ptr <= rd_ptr_nxt;
         cnt    <= cnt_nxt;
         vld_q  <= vld_nxt;
         if (rd_load) rd_q <= rd_src;
         if (f.wr_en && full) ovf_q <= 1'b1;
         if (f.rd_en && empty) udf_q <= 1'b1;
      end
   end

   assign f.full         = full;
   assign f.empty        = empty;
   assign f.almost_full  = (cnt >= f.af_thresh);
   assign f.almost_empty = (cnt <= f.ae_thresh);
   assign f.count        = cnt;
   assign f.rd_data      = rd_q;
   assign f.rd_valid     = vld_q;
   assign f.overflow     = ovf_q;
   assign f.underflow    = udf_q;
endmodule

// File: tb/tb_fifo_sync_ext.sv
// Scoreboard bench for fifo_sync_ext: one standard-mode and one
// FWFT-mode instance share clock and reset.
module tb_fifo_sync_ext;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fifo_sync_ext_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) fa ();
   fifo_sync_ext_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) fb ();

   fifo_sync_ext #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .FWFT(0)) u_a (
      .clk(clk), .rst_n(rst_n), .f(fa.slave));
   fifo_sync_ext #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .FWFT(1)) u_b (
      .clk(clk), .rst_n(rst_n), .f(fb.slave));

   int tests = 0;
   int fails = 0;
   int ma = 0;
   int mb = 0;
   logic [15:0] ea [$];
   logic [15:0] eb [$];
   logic [15:0] ew_a, ew_b;

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   // standard mode: every rd_valid cycle must present the next word
   always @(negedge clk) begin
      if (rst_n && fa.rd_valid) begin
         tests++;
         if (ea.size() == 0) begin
            fails++;
            $display("FAIL sb_a: got %h expected no word", fa.rd_data);
         end else begin
            ew_a = ea.pop_front();
            if (fa.rd_data !== ew_a) begin
               fails++;
               $display("FAIL sb_a: got %h expected %h", fa.rd_data, ew_a);
            end
         end
      end
   end

   // FWFT mode: the word shown while rd_en is high is the one consumed
   always @(negedge clk) begin
      if (rst_n && fb.rd_valid && fb.rd_en) begin
         tests++;
         if (eb.size() == 0) begin
            fails++;
            $display("FAIL sb_b: got %h expected no word", fb.rd_data);
         end else begin
            ew_b = eb.pop_front();
            if (fb.rd_data !== ew_b) begin
               fails++;
               $display("FAIL sb_b: got %h expected %h", fb.rd_data, ew_b);
            end
         end
      end
   end

   task automatic op_a(input logic w, input logic [15:0] d,
                       input logic r, input logic fl = 1'b0);
      bit wa, ra;
      fa.wr_en = w; fa.wr_data = d; fa.rd_en = r; fa.flush = fl;
      if (fl) begin
         ea.delete();
         ma = 0;
      end else begin
         wa = w && (ma < 16);
         ra = r && (ma > 0);
         if (wa) ea.push_back(d);
         ma = ma + int'(wa) - int'(ra);
      end
      @(posedge clk); #1;
      fa.wr_en = 1'b0; fa.rd_en = 1'b0; fa.flush = 1'b0;
   endtask

   task automatic op_b(input logic w, input logic [15:0] d,
                       input logic r);
      bit wa, ra;
      fb.wr_en = w; fb.wr_data = d; fb.rd_en = r;
      wa = w && (mb < 16);
      ra = r && (mb > 0);
      if (wa) eb.push_back(d);
      mb = mb + int'(wa) - int'(ra);
      @(posedge clk); #1;
      fb.wr_en = 1'b0; fb.rd_en = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      fa.flush = 0; fa.wr_en = 0; fa.rd_en = 0; fa.wr_data = '0;
      fb.flush = 0; fb.wr_en = 0; fb.rd_en = 0; fb.wr_data = '0;
      fa.af_thresh = 5'd14; fa.ae_thresh = 5'd2;
      fb.af_thresh = 5'd14; fb.ae_thresh = 5'd2;
      #12;
      chk("rst_empty", fa.empty, 1);
      chk("rst_ae", fa.almost_empty, 1);
      chk("rst_full", fa.full, 0);
      chk("rst_af", fa.almost_full, 0);
      chk("rst_count", fa.count, 0);
      chk("rst_valid", fa.rd_valid, 0);
      chk("rst_data", fa.rd_data, 0);
      chk("rst_b_valid", fb.rd_valid, 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // standard mode fill, overflow, drain
      for (int i = 1; i <= 16; i++) begin
         op_a(1'b1, 16'(i), 1'b0);
         chk("fill_count", fa.count, i);
         chk("fill_af", fa.almost_full, (i >= 14));
      end
      chk("fill_full", fa.full, 1);
      op_a(1'b1, 16'h0099, 1'b0);
      chk("ovf_flag", fa.overflow, 1);
      chk("ovf_count", fa.count, 16);
      for (int i = 0; i < 16; i++) op_a(1'b0, '0, 1'b1);
      op_a(1'b0, '0, 1'b0);
      chk("drain_empty", fa.empty, 1);
      chk("drain_valid", fa.rd_valid, 0);
      chk("drain_udf", fa.underflow, 0);

      op_a(1'b1, 16'hDEAD, 1'b1, 1'b1);
      chk("fl1_count", fa.count, 0);
      chk("fl1_ovf", fa.overflow, 0);
      chk("fl1_udf", fa.underflow, 0);

      // concurrent read/write across pointer wrap
      for (int i = 0; i < 8; i++) op_a(1'b1, 16'(16'h0100 + i), 1'b0);
      for (int i = 0; i < 40; i++) op_a(1'b1, 16'(16'h0200 + i), 1'b1);
      chk("wrap_count", fa.count, 8);
      for (int i = 0; i < 8; i++) op_a(1'b1, 16'(16'h0300 + i), 1'b0);
      chk("wrap_full", fa.full, 1);
      op_a(1'b1, 16'h0BAD, 1'b1);
      chk("rw_full_ovf", fa.overflow, 1);
      chk("rw_full_count", fa.count, 15);
      for (int i = 0; i < 15; i++) op_a(1'b0, '0, 1'b1);
      op_a(1'b0, '0, 1'b0);
      chk("rw_drain_count", fa.count, 0);
      op_a(1'b1, 16'h0777, 1'b1);
      chk("rw_empty_udf", fa.underflow, 1);
      chk("rw_empty_count", fa.count, 1);
      op_a(1'b0, '0, 1'b1);
      op_a(1'b0, '0, 1'b0);

      // thresholds then flush with a write pending
      op_a(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) op_a(1'b1, 16'(16'h0500 + i), 1'b0);
      chk("thr_af14", fa.almost_full, 0);
      fa.af_thresh = 5'd4; #1;
      chk("thr_af4", fa.almost_full, 1);
      fa.af_thresh = 5'd5; #1;
      chk("thr_af5", fa.almost_full, 1);
      fa.ae_thresh = 5'd16; #1;
      chk("thr_ae16", fa.almost_empty, 1);
      fa.ae_thresh = 5'd2; #1;
      chk("thr_ae2", fa.almost_empty, 0);
      fa.af_thresh = 5'd14;
      op_a(1'b1, 16'hDEAD, 1'b0, 1'b1);
      chk("fl2_count", fa.count, 0);
      chk("fl2_ovf", fa.overflow, 0);
      chk("fl2_empty", fa.empty, 1);
      op_a(1'b1, 16'h0ABC, 1'b0);
      op_a(1'b0, '0, 1'b1);
      op_a(1'b0, '0, 1'b0);

      // first-word-fall-through
      op_b(1'b1, 16'hA5A5, 1'b0);
      chk("fwft_valid", fb.rd_valid, 1);
      chk("fwft_data", fb.rd_data, 16'hA5A5);
      chk("fwft_count", fb.count, 1);
      op_b(1'b0, '0, 1'b1);
      chk("fwft_rd_valid", fb.rd_valid, 0);
      chk("fwft_rd_count", fb.count, 0);
      chk("fwft_hold", fb.rd_data, 16'hA5A5);
      op_b(1'b1, 16'hC001, 1'b0);
      op_b(1'b1, 16'hC002, 1'b1);
      chk("fwft_rw_data", fb.rd_data, 16'hC002);
      chk("fwft_rw_count", fb.count, 1);
      op_b(1'b0, '0, 1'b1);
      for (int i = 0; i < 16; i++) op_b(1'b1, 16'(16'hB000 + i), 1'b0);
      chk("fwft_full", fb.full, 1);
      chk("fwft_head", fb.rd_data, 16'hB000);
      op_b(1'b1, 16'hFFFF, 1'b0);
      chk("fwft_ovf", fb.overflow, 1);
      for (int i = 0; i < 16; i++) op_b(1'b0, '0, 1'b1);
      chk("fwft_empty", fb.empty, 1);
      chk("fwft_end_valid", fb.rd_valid, 0);

      // asynchronous reset in the middle of a burst
      op_a(1'b1, 16'h0011, 1'b0);
      op_a(1'b1, 16'h0022, 1'b0);
      op_a(1'b1, 16'h0033, 1'b1);
      fa.wr_en = 1'b1; fa.wr_data = 16'h0044;
      #3 rst_n = 1'b0;
      #1;
      chk("arst_count", fa.count, 0);
      chk("arst_empty", fa.empty, 1);
      chk("arst_valid", fa.rd_valid, 0);
      chk("arst_data", fa.rd_data, 0);
      chk("arst_b_count", fb.count, 0);
      chk("arst_b_ovf", fb.overflow, 0);
      fa.wr_en = 1'b0;
      ea.delete(); eb.delete(); ma = 0; mb = 0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      op_a(1'b1, 16'h1234, 1'b0);
      chk("post_count", fa.count, 1);
      op_a(1'b0, '0, 1'b1);
      chk("post_data", fa.rd_data, 16'h1234);
      op_a(1'b0, '0, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      chk("sb_a_left", ea.size(), 0);
      chk("sb_b_left", eb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/fifo_sync_ext.md
Name: fifo_sync_ext

Overview:
Parametrised synchronous single-clock FIFO, the next generation of the team's basic sync FIFO. Adds a selectable read mode (standard registered read or first-word-fall-through), a live fill count, runtime-programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush. Used as a generic buffer between command/data producers and consumers in the same clock domain.

Parameters:
DATA_WIDTH, 16, word width in bits.
ADDR_WIDTH, 4, capacity DEPTH = 2^ADDR_WIDTH words; must be >= 2.
FWFT, 0, read mode: 0 = standard (data one cycle after rd_en), 1 = first-word-fall-through.

Ports:
clk  in  1  clock; all logic on rising edge.
rst_n  in  1  asynchronous, active-low reset.
flush  in  1  synchronous clear, highest priority.
wr_data  in  DATA_WIDTH  write word.
wr_en  in  1  write request.
full  out  1  count == DEPTH.
almost_full  out  1  count >= af_thresh.
rd_en  in  1  read request (standard mode) / acknowledge (FWFT mode).
rd_data  out  DATA_WIDTH  read word, registered.
rd_valid  out  1  rd_data qualifier (see Behaviour).
empty  out  1  count == 0.
almost_empty  out  1  count <= ae_thresh.
af_thresh  in  ADDR_WIDTH+1  almost-full threshold, unsigned.
ae_thresh  in  ADDR_WIDTH+1  almost-empty threshold, unsigned.
count  out  ADDR_WIDTH+1  words held, 0..DEPTH, registered.
overflow  out  1  sticky: write attempted while full.
underflow  out  1  sticky: read attempted while empty.

Behaviour:
- Reset (rst_n low, async): pointers = 0, count = 0, rd_data = 0, rd_valid = 0, overflow = underflow = 0. Hence full = 0, empty = 1, almost_empty = 1, almost_full = (af_thresh == 0).
- Write accepted iff wr_en && !full at the clock edge. Read accepted iff rd_en && !empty (empty sampled before the edge). Both may occur in one cycle; count then unchanged.
- Full with rd_en && wr_en: read accepted, write rejected and sets overflow. Empty with both: write accepted, read rejected and sets underflow.
- count: +1 on accepted write only, -1 on accepted read only. Updates on the accepting edge. full/empty are derived from count, as are almost_full/almost_empty, which also depend combinationally on the current threshold inputs. A threshold change takes effect the same cycle.
- Pointers: binary, ADDR_WIDTH+1 bits, wrap modulo 2*DEPTH. The memory index is the low ADDR_WIDTH bits. Correct across any number of wraps.
- Standard mode (FWFT=0):
  - An accepted read at edge N loads rd_data with the head word at edge N. rd_valid is high for exactly the cycle after N.
  - rd_data holds its value otherwise. rd_valid is low after a rejected read.
- FWFT mode (FWFT=1):
  - rd_valid == !empty. rd_data shows the head word whenever rd_valid = 1.
  - A write into an empty FIFO at edge N appears on rd_data with rd_valid = 1 after edge N (same edge as count = 1).
  - An accepted read at edge N presents the next word after N, or drops rd_valid if count becomes 0. rd_data holds its last value when rd_valid = 0.
  - Capacity is DEPTH words, including the output register.
- overflow/underflow: set on the edge of the offending request. Cleared only by flush or reset.
- flush (sync): at the edge, clears pointers, count, rd_valid, overflow and underflow; rd_data is held. wr_en and rd_en in the same cycle are ignored and do not set error flags.
- Thresholds above DEPTH: almost_full never asserts. ae_thresh >= DEPTH: almost_empty always asserts.

Test Plan:
- Reset, DW=16, AW=4, af=14, ae=2 -> empty=1, almost_empty=1, full=0, almost_full=0, count=0, rd_valid=0, rd_data=0.
- FWFT=0: write 0x0001..0x0010 (16 words) -> full=1, count=16, almost_full=1 from count=14. Extra write sets overflow=1, count stays 16. Read 16 -> rd_data 0x0001..0x0010 each one cycle after rd_en with rd_valid pulse; then empty=1.
- FWFT=1: write 0xA5A5 into empty FIFO -> next cycle rd_valid=1, rd_data=0xA5A5 with no rd_en. rd_en for one cycle -> rd_valid=0, count=0.
- Simultaneous rd_en+wr_en at count=8 for 40 cycles (pointer wrap) -> count stays 8, data order preserved. At full: write rejected, overflow=1. At empty: underflow=1, count=1.
- Change af_thresh 14->4 at count=5 -> almost_full=1 same cycle. Then flush with wr_en=1 -> count=0, overflow=underflow=0, no write stored.
- Assert rst_n low mid-burst, asynchronously between edges -> all outputs at reset values immediately. After release, the first write reads back correctly.
